alu181_nslice: RTL and testbench
================================

Name: alu181_nslice

Overview:
- Parametrised, registered successor to the 4-bit 181-type ALU slice.
- Implements the full 16-function logic set and the 16-function arithmetic set over a WIDTH-bit word.
- Processes SLICE bits per clock, with the carry held in a flip-flop between slices. SLICE=WIDTH gives a single-cycle ALU; smaller SLICE gives a compact multi-cycle datapath.
- Holds the last result as an accumulator, which can be fed back as the B operand. It sits behind a microsequencer that issues start/done transactions.

Parameters:
- WIDTH, 16: data width in bits. Must be a multiple of SLICE and at least 4.
- SLICE, 4: bits processed per clock. Must divide WIDTH. N = WIDTH/SLICE cycles per operation.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request an operation; sampled only while idle.
- a  in  WIDTH  operand A; captured when start is accepted.
- b  in  WIDTH  operand B; captured when start is accepted and use_acc=0.
- use_acc  in  1  1: B operand is the current f register instead of b.
- s  in  4  function select; captured with start.
- m  in  1  mode: 1 = logic, 0 = arithmetic; captured with start.
- cin  in  1  carry in, active-high (1 = add one); captured with start and ignored when m=1.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; f and all flags are valid and updated in this cycle.
- f  out  WIDTH  result / accumulator register; holds its value between operations.
- cout  out  1  true carry out of the MSB (active-high).
- eq  out  1  &f (all ones). Gives A=B when s=6, m=0, cin=0.
- ovf  out  1  signed overflow.

Behaviour:
- Per-bit terms:
  - X = A | (B & s[0]) | (~B & s[1])
  - Y = (A & ~B & s[2]) | (A & B & s[3])
- Arithmetic (m=0): F = X + Y + cin, with carry rippling across slices.
  - s=0 gives A+cin.
  - s=6 gives A-B-1+cin.
  - s=9 gives A+B+cin.
  - s=3 gives all-ones+cin.
  - s=12 gives A+A+cin.
- Logic (m=1): F = ~(X ^ Y) bitwise; carry forced to 0.
  - s=0 gives ~A.
  - s=6 gives A^B.
  - s=11 gives A&B.
  - s=14 gives A|B.
  - s=15 gives A.
- State machine with two states, IDLE and RUN.
  - IDLE, start=1: capture a, b-or-f, s, m; carry_ff = cin & ~m; slice counter k=0; go to RUN; busy=1.
  - IDLE, start=0: no change.
  - RUN: each cycle computes bits [k*SLICE +: SLICE] from the captured operands and carry_ff, writes them to an internal shadow result, updates carry_ff, and increments k.
  - RUN, final slice (k=N-1): copy the shadow to f atomically and update cout, eq, ovf. Assert done for exactly one cycle, deassert busy, return to IDLE.
- f never shows a partially computed word.
- Latency: start sampled at edge t gives done high after edge t+N.
- Throughput: a start presented while done=1 is accepted, so one operation every N+1 cycles.
- A start presented during RUN is ignored, not queued.
- use_acc=1 with start in the done cycle uses the newly written f.
- Inputs a, b, s, m, cin, use_acc may change freely after acceptance without affecting the operation.
- ovf: carry into the MSB XOR carry out of the MSB; 0 when m=1. cout is 0 when m=1.
- Reset, including mid-operation:
  - state=IDLE, k=0, carry_ff=0.
  - f=0, busy=0, done=0, cout=0, ovf=0.
  - eq reflects f=0, so eq=0.
  - An in-flight operation is discarded and no done is produced.
  - rst has priority over start in the same cycle.
- Wrap-around: the arithmetic result is modulo 2^WIDTH; the carry beyond the MSB appears only on cout.

Test Plan:
- WIDTH=16, SLICE=4, m=0, s=9, cin=0, a=0x1234, b=0x0FFF, pulse start -> busy for 4 cycles, done on the 4th edge after start, f=0x2233, cout=0, ovf=0, eq=0.
- m=0, s=6, cin=1, a=0x0005, b=0x0007 -> f=0xFFFE, cout=0. Then a=b=0x5A5A, cin=0 -> f=0xFFFF, eq=1, cout=0.
- m=0, s=9, cin=0, a=0x7FFF, b=0x0001 -> f=0x8000, ovf=1, cout=0. Then a=0xFFFF, b=0x0001 -> f=0x0000, cout=1, ovf=0.
- m=1, s=6, cin=1, a=0xF0F0, b=0xFF00 -> f=0x0FF0, cout=0, ovf=0 (cin ignored).
- After reset, use_acc=1, m=0, s=9, cin=0, a=0x0001:
  - Issue start three times, each in the done cycle of the previous operation -> f=0x0001, 0x0002, 0x0003.
  - An extra start pulse mid-RUN -> no extra done and no change to f.
- rst asserted on the 2nd RUN cycle -> next cycle busy=0, f=0x0000, no done pulse.
- Instance with SLICE=16, s=9, a=0x0002, b=0x0003 -> done one edge after start, f=0x0005.

Source files
------------

// File: rtl/alu181_nslice.sv
// Registered, bit-serial-by-slice 181-type ALU: SLICE bits per clock, carry held between slices,
// result published atomically into an accumulator register f that can be fed back as operand B.
`timescale 1ns/1ps
module alu181_nslice #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             use_acc,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             eq,
  output logic             ovf
);

  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_reg;
  logic [KW-1:0]    k_reg;
  logic [WIDTH-1:0] a_reg, b_reg, shadow_reg, f_reg;
  logic [3:0]       s_reg;
  logic             m_reg, carry_reg, done_reg, cout_reg, ovf_reg;

  logic [SLICE-1:0] a_sl, b_sl, x_sl, y_sl, res_sl;
  logic [SLICE:0]   sum_sl;
  logic [WIDTH-1:0] shadow_next;
  logic             carry_next, msb_carry_in, last_slice;

  assign a_sl = a_reg[int'(k_reg)*SLICE +: SLICE];
  assign b_sl = b_reg[int'(k_reg)*SLICE +: SLICE];

  genvar gi;
  generate
    for (gi = 0; gi < SLICE; gi++) begin : g_bit
      assign x_sl[gi] = a_sl[gi] | (b_sl[gi] & s_reg[0]) | (~b_sl[gi] & s_reg[1]);
      assign y_sl[gi] = (a_sl[gi] & ~b_sl[gi] & s_reg[2]) | (a_sl[gi] & b_sl[gi] & s_reg[3]);
    end
  endgenerate

  assign sum_sl     = {1'b0, x_sl} + {1'b0, y_sl} + {{SLICE{1'b0}}, carry_reg};
  assign res_sl     = m_reg ? ~(x_sl ^ y_sl) : sum_sl[SLICE-1:0];
  assign carry_next = m_reg ? 1'b0 : sum_sl[SLICE];
  // Carry into the top bit recovered from its sum bit: c_in = x ^ y ^ sum.
  assign msb_carry_in = x_sl[SLICE-1] ^ y_sl[SLICE-1] ^ sum_sl[SLICE-1];
  assign last_slice   = (k_reg == KW'(N - 1));

  always_comb begin
    shadow_next = shadow_reg;
    shadow_next[int'(k_reg)*SLICE +: SLICE] = res_sl;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      carry_reg <= 1'b0;
      f_reg     <= '0;
      done_reg  <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= use_acc ? f_reg : b;
            s_reg     <= s;
            m_reg     <= m;
            carry_reg <= cin & ~m;
            k_reg     <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          shadow_reg <= shadow_next;
          carry_reg  <= carry_next;
          k_reg      <= k_reg + 1'b1;
          if (last_slice) begin
            // Publish the whole word at once so f never shows a partial result.
            f_reg     <= shadow_next;
            cout_reg  <= carry_next;
            ovf_reg   <= ~m_reg & (msb_carry_in ^ sum_sl[SLICE]);
            done_reg  <= 1'b1;
            k_reg     <= '0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg == RUN);
  assign done = done_reg;
  assign f    = f_reg;
  assign cout = cout_reg;
  assign ovf  = ovf_reg;
  assign eq   = &f_reg;

endmodule

// File: tb/tb_alu181_nslice.sv
// Scoreboard bench for alu181_nslice: a 4-bit-slice and a full-width instance, driven by
// directed and random operations, checked against a word-level reference model.
`timescale 1ns/1ps
module tb_alu181_nslice;

  typedef struct {
    logic [15:0] f;
    logic        cout;
    logic        eq;
    logic        ovf;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, use_acc, m, cin;
  logic [15:0] a, b;
  logic [3:0]  s;
  logic        busy, done, cout, eq, ovf;
  logic [15:0] f;

  logic        start2, use_acc2, m2, cin2;
  logic [15:0] a2, b2;
  logic [3:0]  s2;
  logic        busy2, done2, cout2, eq2, ovf2;
  logic [15:0] f2;

  alu181_nslice #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .use_acc(use_acc), .s(s), .m(m),
    .cin(cin), .busy(busy), .done(done), .f(f), .cout(cout), .eq(eq), .ovf(ovf));

  alu181_nslice #(.WIDTH(16), .SLICE(16)) dut16 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .use_acc(use_acc2), .s(s2), .m(m2),
    .cin(cin2), .busy(busy2), .done(done2), .f(f2), .cout(cout2), .eq(eq2), .ovf(ovf2));

  exp_t        q4[$];
  exp_t        q16[$];
  logic [15:0] acc4, acc16;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Word-level reference: X/Y terms, then plain 17-bit addition or bitwise XNOR.
  function automatic exp_t model(input logic [15:0] ta, input logic [15:0] tb_,
                                 input logic [3:0] ts, input logic tm, input logic tc);
    exp_t        r;
    logic [15:0] x, y;
    logic [16:0] sum;
    x = ta | (tb_ & {16{ts[0]}}) | (~tb_ & {16{ts[1]}});
    y = (ta & ~tb_ & {16{ts[2]}}) | (ta & tb_ & {16{ts[3]}});
    if (tm) begin
      r.f = ~(x ^ y);
      r.cout = 1'b0;
      r.ovf = 1'b0;
    end else begin
      sum = {1'b0, x} + {1'b0, y} + {16'd0, tc};
      r.f = sum[15:0];
      r.cout = sum[16];
      r.ovf = (x[15] == y[15]) && (r.f[15] != x[15]);
    end
    r.eq = &r.f;
    r.cyc = 0;
    return r;
  endfunction

  // Call at a negedge; waits for the chosen DUT to be idle, pulses start for one cycle.
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic tu,
                       input logic [3:0] ts, input logic tm, input logic tc, input bit wide);
    int   waited = 0;
    exp_t e;
    while ((wide ? busy2 : busy) === 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if ((wide ? busy2 : busy) !== 1'b0) begin
      chk("idle_wait_timeout", 32'(wide ? busy2 : busy), 32'd0);
      return;
    end
    if (wide) begin
      a2 = ta; b2 = tb_; use_acc2 = tu; s2 = ts; m2 = tm; cin2 = tc; start2 = 1'b1;
      e = model(ta, tu ? acc16 : tb_, ts, tm, tc);
      e.cyc = cyc + 2;
      q16.push_back(e);
      acc16 = e.f;
    end else begin
      a = ta; b = tb_; use_acc = tu; s = ts; m = tm; cin = tc; start = 1'b1;
      e = model(ta, tu ? acc4 : tb_, ts, tm, tc);
      e.cyc = cyc + 5;
      q4.push_back(e);
      acc4 = e.f;
    end
    @(negedge clk);
    start = 1'b0; start2 = 1'b0;
    // Scramble inputs after acceptance; they must not affect the operation.
    a = 16'($urandom); b = 16'($urandom); s = 4'($urandom); m = 1'($urandom); cin = 1'($urandom);
    use_acc = 1'($urandom);
    a2 = 16'($urandom); b2 = 16'($urandom); s2 = 4'($urandom); m2 = 1'($urandom);
    cin2 = 1'($urandom); use_acc2 = 1'($urandom);
  endtask

  initial begin : mon4
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (q4.size() == 0) chk("unexpected_done4", 32'd1, 32'd0);
        else begin
          e = q4.pop_front();
          $display("slice4  f=%h cout=%b eq=%b ovf=%b (exp f=%h cout=%b eq=%b ovf=%b) cyc=%0d",
                   f, cout, eq, ovf, e.f, e.cout, e.eq, e.ovf, cyc);
          chk("f4", 32'(f), 32'(e.f));
          chk("cout4", 32'(cout), 32'(e.cout));
          chk("eq4", 32'(eq), 32'(e.eq));
          chk("ovf4", 32'(ovf), 32'(e.ovf));
          chk("latency4", 32'(cyc), 32'(e.cyc));
          chk("busy_at_done4", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin : mon16
    exp_t e;
    forever begin
      @(negedge clk);
      if (done2 === 1'b1) begin
        if (q16.size() == 0) chk("unexpected_done16", 32'd1, 32'd0);
        else begin
          e = q16.pop_front();
          $display("slice16 f=%h cout=%b eq=%b ovf=%b (exp f=%h cout=%b eq=%b ovf=%b) cyc=%0d",
                   f2, cout2, eq2, ovf2, e.f, e.cout, e.eq, e.ovf, cyc);
          chk("f16", 32'(f2), 32'(e.f));
          chk("cout16", 32'(cout2), 32'(e.cout));
          chk("eq16", 32'(eq2), 32'(e.eq));
          chk("ovf16", 32'(ovf2), 32'(e.ovf));
          chk("latency16", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic drain();
    int waited = 0;
    while ((q4.size() != 0 || q16.size() != 0) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("drain", 32'(q4.size() + q16.size()), 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_f"}, 32'(f), 32'd0);
    chk({tag, "_cout"}, 32'(cout), 32'd0);
    chk({tag, "_eq"}, 32'(eq), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; use_acc = 1'b0; s = '0; m = 1'b0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; use_acc2 = 1'b0; s2 = '0; m2 = 1'b0; cin2 = 1'b0;
    acc4 = '0; acc16 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    chk("reset_busy16", 32'(busy2), 32'd0);
    chk("reset_f16", 32'(f2), 32'd0);

    // Directed arithmetic and logic cases.
    issue(16'h1234, 16'h0FFF, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
    issue(16'h0005, 16'h0007, 1'b0, 4'd6, 1'b0, 1'b1, 1'b0);
    issue(16'h5A5A, 16'h5A5A, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0);
    issue(16'h7FFF, 16'h0001, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
    issue(16'hFFFF, 16'h0001, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
    issue(16'hF0F0, 16'hFF00, 1'b0, 4'd6, 1'b1, 1'b1, 1'b0);

    // Every function in both modes.
    for (int mm = 0; mm < 2; mm++)
      for (int ss = 0; ss < 16; ss++)
        issue(16'($urandom), 16'($urandom), 1'b0, 4'(ss), 1'(mm), 1'($urandom), 1'b0);
    drain();

    // Accumulate from reset: three back-to-back starts, each landing in the done cycle.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; acc4 = '0; acc16 = '0;
    check_reset_state("reset2");
    for (int i = 0; i < 3; i++)
      issue(16'h0001, 16'($urandom), 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);

    // Start pulse during RUN must be ignored.
    issue(16'h0001, 16'($urandom), 1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
    a = 16'hBEEF; b = 16'h1111; use_acc = 1'b0; s = 4'd9; m = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    repeat (6) @(negedge clk);
    chk("f_after_ignored_start", 32'(f), 32'(acc4));

    // Reset on the second RUN cycle discards the operation.
    issue(16'h1234, 16'h4321, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    q4.delete();
    acc4 = '0;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("midrun_reset");
    repeat (6) @(negedge clk);

    // Random traffic on the slice-4 instance.
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
            1'($urandom), 1'b0);
    end
    drain();

    // Single-cycle instance.
    acc16 = f2;
    issue(16'h0002, 16'h0003, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 25; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
            1'($urandom), 1'b1);
    end
    drain();
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
